// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the LittleComputer memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_BAD   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational picker: round-robin by default, fixed priority
// (requester 0 wins) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       idx
);

  always_comb begin
    idx   = REQ_CPU;
    grant = '0;
    if (valid == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      idx = REQ_CPU;
`else
      idx = ~last;
`endif
    end else if (valid[1]) begin
      idx = REQ_LOADER;
    end
    if (|valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU (req 0) and loader (req 1).
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority inside rr_pick2.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_grant;
  logic              w_idx;
  logic              w_accept;

  rr_pick2 u_pick (
    .valid (req_valid),
    .last  (r_last),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign w_accept  = (r_state == ST_IDLE) && (|req_valid);
  assign req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last  <= w_idx;
        r_win   <= w_idx;
        r_we    <= w_idx ? req_we[1] : req_we[0];
        r_addr  <= w_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        r_wdata <= w_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
    end
  end

  // Outputs decode straight from state so an ISSUE/RESP cycle that coincides
  // with reset is still driven to the RAM / requester.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 2'b00;
    resp_rdata = '0;
    if (r_state == ST_ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = r_we;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
    end
    if (r_state == ST_RESP) begin
      resp_valid = {r_win, ~r_win};
      if (!r_we) resp_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural RAM.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and give combinational outputs time to settle.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned r, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]        = v;
    req_we[r]           = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  logic [1:0] exp_rdy;
  int unsigned n_resp;
  int unsigned n_g0;

  initial begin
    reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = 15'h0010; pre_data = 16'hBEEF;
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_ready_idle", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    pre_en = 1'b0; reset = 1'b0;

    // Single read
    set_req(0, 1'b1, 1'b0, 15'h0010, 16'h0000);
    #1; chk("rd_ready_T", {30'd0, req_ready}, 32'h1);
    next_cyc(); set_req(0, 1'b0, 1'b0, 15'h0010, 16'h0000); #1;
    chk("rd_mem_en_T1", {31'd0, mem_en}, 32'd1);
    chk("rd_mem_we_T1", {31'd0, mem_we}, 32'd0);
    chk("rd_mem_addr_T1", {17'd0, mem_addr}, 32'h10);
    chk("rd_ready_T1", {30'd0, req_ready}, 32'd0);
    next_cyc();
    chk("rd_resp_valid_T2", {30'd0, resp_valid}, 32'h1);
    chk("rd_rdata_T2", {16'd0, resp_rdata}, 32'hBEEF);
    next_cyc();
    chk("rd_resp_done", {30'd0, resp_valid}, 32'd0);

    // Write then read from loader at top address
    set_req(1, 1'b1, 1'b1, 15'h7FFF, 16'h1234); #1;
    chk("wr_ready", {30'd0, req_ready}, 32'h2);
    next_cyc(); set_req(1, 1'b0, 1'b1, 15'h7FFF, 16'h1234); #1;
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
    chk("wr_mem_addr", {17'd0, mem_addr}, 32'h7FFF);
    next_cyc();
    chk("wr_resp_valid", {30'd0, resp_valid}, 32'h2);
    chk("wr_rdata_zero", {16'd0, resp_rdata}, 32'd0);
    next_cyc();
    set_req(1, 1'b1, 1'b0, 15'h7FFF, 16'h0000); #1;
    chk("rb_ready", {30'd0, req_ready}, 32'h2);
    next_cyc(); set_req(1, 1'b0, 1'b0, 15'h7FFF, 16'h0000);
    next_cyc();
    chk("rb_resp_valid", {30'd0, resp_valid}, 32'h2);
    chk("rb_rdata", {16'd0, resp_rdata}, 32'h1234);

    // Reset in IDLE with a request present: nothing latched
    next_cyc();
    reset = 1'b1; set_req(0, 1'b1, 1'b1, 15'h0020, 16'h5555);
    next_cyc();
    reset = 1'b0; set_req(0, 1'b0, 1'b0, 15'h0000, 16'h0000); #1;
    chk("rst_idle_no_issue", {31'd0, mem_en}, 32'd0);

    // Contention: both valid for 12 cycles (last_grant=1 after reset)
    set_req(0, 1'b1, 1'b0, 15'h0010, 16'h0000);
    set_req(1, 1'b1, 1'b0, 15'h7FFF, 16'h0000);
    n_resp = 0; n_g0 = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_rdy = (i % 3 == 0) ? 2'b01 : 2'b00;
`else
      exp_rdy = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
`endif
      chk($sformatf("cont_ready_c%0d", i), {30'd0, req_ready}, {30'd0, exp_rdy});
      if (req_ready[0]) n_g0++;
      if (|resp_valid) n_resp++;
      @(negedge clk);
    end
    chk("cont_resp_count", n_resp, 32'd4);
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("cont_g0_count", n_g0, 32'd4);
`else
    chk("cont_g0_count", n_g0, 32'd2);
`endif
    set_req(0, 1'b0, 1'b0, 15'h0000, 16'h0000); #1;
    chk("cont_req1_after_drop", {30'd0, req_ready}, 32'h2);
    next_cyc(); set_req(1, 1'b0, 1'b0, 15'h0000, 16'h0000);
    next_cyc();
    chk("cont_tail_resp", {30'd0, resp_valid}, 32'h2);
    next_cyc();

    // Reset during ISSUE: write lands, no response
    set_req(0, 1'b1, 1'b1, 15'h0005, 16'hAAAA); #1;
    chk("ri_ready", {30'd0, req_ready}, 32'h1);
    next_cyc(); set_req(0, 1'b0, 1'b0, 15'h0000, 16'h0000); reset = 1'b1; #1;
    chk("ri_mem_en", {31'd0, mem_en}, 32'd1);
    chk("ri_mem_we", {31'd0, mem_we}, 32'd1);
    next_cyc(); reset = 1'b0; #1;
    chk("ri_no_resp", {30'd0, resp_valid}, 32'd0);
    chk("ri_ram", {16'd0, ram[15'h0005]}, 32'hAAAA);
    set_req(1, 1'b1, 1'b0, 15'h0005, 16'h0000); #1;
    chk("ri_idle_ready", {30'd0, req_ready}, 32'h2);
    next_cyc(); set_req(1, 1'b0, 1'b0, 15'h0000, 16'h0000);
    next_cyc();
    chk("ri_readback", {16'd0, resp_rdata}, 32'hAAAA);
    next_cyc();

    // Request raised during RESP waits for IDLE
    set_req(0, 1'b1, 1'b0, 15'h0010, 16'h0000); #1;
    chk("rr_ready0_T", {30'd0, req_ready}, 32'h1);
    next_cyc(); set_req(0, 1'b0, 1'b0, 15'h0000, 16'h0000);
    next_cyc(); set_req(1, 1'b1, 1'b0, 15'h7FFF, 16'h0000); #1;
    chk("rr_resp_T2", {30'd0, resp_valid}, 32'h1);
    chk("rr_ready_T2", {30'd0, req_ready}, 32'd0);
    next_cyc();
    chk("rr_ready_T3", {30'd0, req_ready}, 32'h2);
    next_cyc(); set_req(1, 1'b0, 1'b0, 15'h0000, 16'h0000);
    next_cyc();
    chk("rr_resp1", {30'd0, resp_valid}, 32'h2);
    chk("rr_rdata1", {16'd0, resp_rdata}, 32'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port synchronous 16-bit RAM between a CPU data port (requester 0) and a loader/DMA port (requester 1). It accepts one request at a time, issues it to the RAM, and returns a response to the winning requester. It sits between the CPU/loader and the data memory in the LittleComputer memory subsystem.

## Interface
- `ADDR_W`, 15: RAM word-address width.
- `DATA_W`, 16: data word width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 2: per-requester request strobe; bit i belongs to requester i.
- `req_we` input 2: per-requester write enable (1 = write, 0 = read).
- `req_addr` input 2×ADDR_W: per-requester address, packed; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata` input 2×DATA_W: per-requester write data, packed the same way.
- `req_ready` output 2: one-hot acceptance; a request is accepted in the cycle where both `req_valid[i]` and `req_ready[i]` are high.
- `resp_valid` output 2: one-cycle, one-hot completion pulse.
- `resp_rdata` output DATA_W: read data, shared by both requesters and qualified by `resp_valid`.
- `mem_en`, `mem_we` output 1: RAM enable and write enable.
- `mem_addr` output ADDR_W: RAM address.
- `mem_wdata` output DATA_W: RAM write data.
- `mem_rdata` input DATA_W: RAM read data, valid one cycle after `mem_en` with `mem_we` = 0.

## Operation
- FSM states: IDLE, ISSUE, RESP. Encoding is 2 bits; 2'b11 is illegal and recovers to IDLE.
- IDLE:
  - If any `req_valid` bit is high, the picker selects winner w and `req_ready[w]` = 1 (combinational on `req_valid` and `last_grant`).
  - On acceptance the block latches we, addr, wdata and w, sets `last_grant` = w, and moves to ISSUE.
  - If no request is valid, it stays in IDLE.
- ISSUE: `mem_en` = 1. `mem_we`, `mem_addr` and `mem_wdata` come from the latched values. Next state is RESP.
- RESP:
  - `resp_valid[w]` = 1.
  - `resp_rdata` = `mem_rdata` for a read and 16'h0000 for a write.
  - Next state is IDLE.
- Arbitration (default): round-robin. With both requesters valid, the winner is the requester that is not `last_grant`. With one valid, that one wins.
- `req_ready` is 0 in ISSUE and RESP. A requester must hold `req_valid` and its payload stable until accepted; dropping `req_valid` early is a protocol violation and behaviour is undefined.
- Memory outputs are zero whenever the state is not ISSUE.

## Timing
- Reset values: state = IDLE, `last_grant` = 1 (requester 0 wins the first contention), latched payload = 0. All outputs read 0 except `req_ready`, which stays combinational on `req_valid`.
- Latency: accepted at cycle T, `mem_en` at T+1, `resp_valid` at T+2. Earliest next acceptance is T+3, so peak throughput is one access per 3 cycles.
- `req_valid` asserted during RESP is not accepted until the following IDLE cycle.
- Reset asserted in ISSUE: `mem_en` and `mem_we` are still driven that cycle, so the write lands in RAM. The state then goes to IDLE and no `resp_valid` is produced.
- Reset asserted in RESP: `resp_valid` is still driven that cycle. The state then goes to IDLE.
- Reset asserted in IDLE together with `req_valid`: `req_ready` may be high, but the request is not latched; reset wins.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins contention, and `last_grant` is still updated but ignored.
- `MEM_ARB_FIXED_PRIO_EN` undefined: round-robin as described under Operation.

## Structure
- Package `mem_arb_pkg` holds:
  - state encodings `ST_IDLE` = 2'd0, `ST_ISSUE` = 2'd1, `ST_RESP` = 2'd2;
  - default widths `ADDR_W` = 15, `DATA_W` = 16;
  - requester index constants `REQ_CPU` = 0, `REQ_LOADER` = 1.
- Sub-module `rr_pick2`: a combinational picker with inputs `valid[1:0]` and `last`, and outputs one-hot `grant[1:0]` and `idx`. The `MEM_ARB_FIXED_PRIO_EN` switch lives inside it.

## Test plan
- Single read: reset, preload RAM[0x0010] = 16'hBEEF, req0 read 0x0010 -> `req_ready[0]` at T, `mem_en` = 1 and `mem_we` = 0 at T+1, `resp_valid` = 2'b01 and `resp_rdata` = 16'hBEEF at T+2.
- Write then read: req1 writes 16'h1234 to 0x7FFF -> `resp_valid` = 2'b10 with `resp_rdata` = 0. A following req1 read of 0x7FFF returns 16'h1234.
- Contention, round-robin: both requesters held valid for 12 cycles -> grants alternate 0,1,0,1, one acceptance every 3 cycles, 4 responses total.
- Contention with `MEM_ARB_FIXED_PRIO_EN` defined: same stimulus -> requester 0 receives all 4 grants and requester 1 none until req0 drops.
- Reset in ISSUE: req0 write 16'hAAAA to 0x0005, reset pulsed at T+1 -> RAM[0x0005] = 16'hAAAA, no `resp_valid`, state IDLE at T+2.
- Request during RESP: req1 raised at T+2 of a req0 transaction -> `req_ready[1]` first high at T+3.
